// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, funcs,
// datapath select encodings, FSM states and the decoded-instruction record.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LBU  = 6'b100100;
  localparam logic [5:0] OP_LHU  = 6'b100101;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SH   = 6'b101001;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_DIV  = 6'b011010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BR  = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_OR  = 4'd2;
  localparam logic [3:0] ALU_SLL = 4'd3;
  localparam logic [3:0] ALU_LUI = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_CMP = 4'd6;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_IMM   = 2'd1;
  localparam logic [1:0] SRCB_SHAMT = 2'd2;

  localparam logic [2:0] DM_W  = 3'd0;
  localparam logic [2:0] DM_H  = 3'd1;
  localparam logic [2:0] DM_HU = 3'd2;
  localparam logic [2:0] DM_B  = 3'd3;
  localparam logic [2:0] DM_BU = 3'd4;

  localparam logic [1:0] GWD_ALU  = 2'd0;
  localparam logic [1:0] GWD_DM   = 2'd1;
  localparam logic [1:0] GWD_PC   = 2'd2;
  localparam logic [1:0] GWD_HILO = 2'd3;

  localparam logic [1:0] A3_RT = 2'd0;
  localparam logic [1:0] A3_RD = 2'd1;
  localparam logic [1:0] A3_RA = 2'd2;

  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_EX  = 4'd2,
    S_MEM = 4'd3,
    S_WB  = 4'd4,
    S_BR  = 4'd5,
    S_JMP = 4'd6,
    S_MD  = 4'd7
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU   = 3'd0,
    CL_LOAD  = 3'd1,
    CL_STORE = 3'd2,
    CL_BR    = 3'd3,
    CL_JMP   = 3'd4,
    CL_MD    = 3'd5,
    CL_MF    = 3'd6,
    CL_ILL   = 3'd7
  } iclass_e;

  typedef struct packed {
    iclass_e    cls;
    logic [2:0] npc_sel;
    logic       ext_op;
    logic [1:0] srcb_sel;
    logic [3:0] alu_ctrl;
    logic [2:0] dm_sel;
    logic [1:0] gwd_sel;
    logic [1:0] a3_sel;
    logic       md_op;
    logic       hilo_sel;
    logic       link;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: maps the IR word to its instruction
// class and the per-instruction datapath select values.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign fn          = instr[5:0];
  assign unused_bits = ^instr[25:6];

  // opcode/func to class and select lines
  always_comb begin
    dec.cls      = CL_ILL;
    dec.npc_sel  = NPC_PC4;
    dec.ext_op   = 1'b1;
    dec.srcb_sel = SRCB_RT;
    dec.alu_ctrl = ALU_ADD;
    dec.dm_sel   = DM_W;
    dec.gwd_sel  = GWD_ALU;
    dec.a3_sel   = A3_RT;
    dec.md_op    = 1'b0;
    dec.hilo_sel = 1'b0;
    dec.link     = 1'b0;
    dec.illegal  = 1'b0;
    case (op)
      OP_R: begin
        dec.a3_sel = A3_RD;
        case (fn)
          FN_ADDU: dec.cls = CL_ALU;
          FN_SUBU: begin dec.cls = CL_ALU; dec.alu_ctrl = ALU_SUB; end
          FN_SLL: begin
            dec.cls      = CL_ALU;
            dec.alu_ctrl = ALU_SLL;
            dec.srcb_sel = SRCB_SHAMT;
          end
          FN_JR:   begin dec.cls = CL_JMP; dec.npc_sel = NPC_JR; end
          FN_MULT: dec.cls = CL_MD;
          FN_DIV:  begin dec.cls = CL_MD; dec.md_op = 1'b1; end
          FN_MFHI: begin dec.cls = CL_MF; dec.gwd_sel = GWD_HILO; end
          FN_MFLO: begin
            dec.cls      = CL_MF;
            dec.gwd_sel  = GWD_HILO;
            dec.hilo_sel = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_ORI: begin
        dec.cls = CL_ALU; dec.alu_ctrl = ALU_OR;  dec.srcb_sel = SRCB_IMM; dec.ext_op = 1'b0;
      end
      OP_LUI: begin
        dec.cls = CL_ALU; dec.alu_ctrl = ALU_LUI; dec.srcb_sel = SRCB_IMM; dec.ext_op = 1'b0;
      end
      OP_SLTI: begin
        dec.cls = CL_ALU; dec.alu_ctrl = ALU_SLT; dec.srcb_sel = SRCB_IMM;
      end
      OP_BEQ, OP_BGTZ: begin
        dec.cls = CL_BR; dec.npc_sel = NPC_BR; dec.alu_ctrl = ALU_CMP;
      end
      OP_J: begin dec.cls = CL_JMP; dec.npc_sel = NPC_J; end
      OP_JAL: begin
        dec.cls     = CL_JMP;
        dec.npc_sel = NPC_J;
        dec.link    = 1'b1;
        dec.gwd_sel = GWD_PC;
        dec.a3_sel  = A3_RA;
      end
      OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
        dec.cls      = CL_LOAD;
        dec.srcb_sel = SRCB_IMM;
        dec.gwd_sel  = GWD_DM;
        case (op)
          OP_LH:   dec.dm_sel = DM_H;
          OP_LHU:  dec.dm_sel = DM_HU;
          OP_LB:   dec.dm_sel = DM_B;
          OP_LBU:  dec.dm_sel = DM_BU;
          default: dec.dm_sel = DM_W;
        endcase
      end
      OP_SW, OP_SH, OP_SB: begin
        dec.cls      = CL_STORE;
        dec.srcb_sel = SRCB_IMM;
        case (op)
          OP_SH:   dec.dm_sel = DM_H;
          OP_SB:   dec.dm_sel = DM_B;
          default: dec.dm_sel = DM_W;
        endcase
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: Moore FSM stepping each instruction through
// fetch/decode/execute/memory/write-back, with a latency counter for mult/div.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  output logic        pc_we,
  output logic        ir_we,
  output logic [2:0]  npc_sel,
  output logic        ext_op,
  output logic [1:0]  srcb_sel,
  output logic [3:0]  alu_ctrl,
  output logic        dwe,
  output logic [2:0]  dm_sel,
  output logic [1:0]  gwd_sel,
  output logic [1:0]  a3_sel,
  output logic        gwe,
  output logic        md_start,
  output logic        md_op,
  output logic        hilo_sel,
  output logic        illegal,
  output logic [3:0]  state
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYC - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYC - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] md_load;
  dec_t          dec;
  logic          pc_we_s, ir_we_s, dwe_s, gwe_s, md_start_s, illegal_s;

  mc_decode u_decode (
    .instr (instr),
    .dec   (dec)
  );

  assign md_load = dec.md_op ? DIV_LOAD : MULT_LOAD;

  // state register and MD latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IF;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state and counter update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IF: state_d = S_ID;
      S_ID: begin
        case (dec.cls)
          CL_ALU, CL_LOAD, CL_STORE: state_d = S_EX;
          CL_BR:  state_d = S_BR;
          CL_JMP: state_d = S_JMP;
          CL_MF:  state_d = S_WB;
          CL_MD: begin
            state_d = S_MD;
            cnt_d   = md_load;
          end
          default: state_d = S_IF;
        endcase
      end
      S_EX:  state_d = (dec.cls == CL_ALU) ? S_WB : S_MEM;
      S_MEM: state_d = (dec.cls == CL_LOAD) ? S_WB : S_IF;
      S_WB, S_BR, S_JMP: state_d = S_IF;
      S_MD: begin
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_IF;
        end else begin
          cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = S_IF;
    endcase
  end

  // Moore strobes; md_start is identified by the counter still holding its load value
  always_comb begin
    pc_we_s    = 1'b0;
    ir_we_s    = 1'b0;
    dwe_s      = 1'b0;
    gwe_s      = 1'b0;
    md_start_s = 1'b0;
    illegal_s  = 1'b0;
    case (state_q)
      S_IF:  begin pc_we_s = 1'b1; ir_we_s = 1'b1; end
      S_ID:  illegal_s = dec.illegal;
      S_MEM: dwe_s = (dec.cls == CL_STORE);
      S_WB:  gwe_s = 1'b1;
      S_BR:  pc_we_s = 1'b1;
      S_JMP: begin pc_we_s = 1'b1; gwe_s = dec.link; end
      S_MD:  md_start_s = (cnt_q == md_load);
      default: pc_we_s = 1'b0;
    endcase
  end

  // reset forces every strobe low, even while the state register still holds a mid-instruction state
  assign pc_we    = pc_we_s    & ~reset;
  assign ir_we    = ir_we_s    & ~reset;
  assign dwe      = dwe_s      & ~reset;
  assign gwe      = gwe_s      & ~reset;
  assign md_start = md_start_s & ~reset;
  assign illegal  = illegal_s  & ~reset;

  assign npc_sel  = (state_q == S_IF) ? NPC_PC4 : dec.npc_sel;
  assign ext_op   = dec.ext_op;
  assign srcb_sel = dec.srcb_sel;
  assign alu_ctrl = dec.alu_ctrl;
  assign dm_sel   = dec.dm_sel;
  assign gwd_sel  = dec.gwd_sel;
  assign a3_sel   = dec.a3_sel;
  assign md_op    = dec.md_op;
  assign hilo_sel = dec.hilo_sel;
  assign state    = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomized bench for mc_ctrl: each instruction is expanded into its expected
// cycle-by-cycle sequence from an instruction table and compared per cycle.
module tb_mc_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_EX = 4'd2, ST_MEM = 4'd3;
  localparam logic [3:0] ST_WB = 4'd4, ST_BR = 4'd5, ST_JMP = 4'd6, ST_MD = 4'd7;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_J = 4, K_JAL = 5;
  localparam int K_JR = 6, K_MD = 7, K_MF = 8, K_ILL = 9;

  // strobe vector order: {pc_we, ir_we, dwe, gwe, md_start, illegal}
  localparam logic [5:0] SB_NONE = 6'b000000, SB_IF = 6'b110000, SB_PC = 6'b100000;
  localparam logic [5:0] SB_DWE = 6'b001000, SB_GWE = 6'b000100, SB_MDS = 6'b000010;
  localparam logic [5:0] SB_ILL = 6'b000001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        pc_we, ir_we, ext_op, dwe, gwe, md_start, md_op, hilo_sel, illegal;
  logic [2:0]  npc_sel, dm_sel;
  logic [1:0]  srcb_sel, gwd_sel, a3_sel;
  logic [3:0]  alu_ctrl, state;

  always #5 clk = ~clk;

  mc_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .reset(reset), .instr(instr),
    .pc_we(pc_we), .ir_we(ir_we), .npc_sel(npc_sel), .ext_op(ext_op),
    .srcb_sel(srcb_sel), .alu_ctrl(alu_ctrl), .dwe(dwe), .dm_sel(dm_sel),
    .gwd_sel(gwd_sel), .a3_sel(a3_sel), .gwe(gwe), .md_start(md_start),
    .md_op(md_op), .hilo_sel(hilo_sel), .illegal(illegal), .state(state)
  );

  typedef struct {
    string      nm;
    logic [5:0] op;
    logic [5:0] fn;
    int         k;
    logic [3:0] alu;
    logic [1:0] srcb;
    logic       ext;
    logic [2:0] dm;
    logic [1:0] a3;
    logic       aux;
  } ent_t;

  typedef struct {
    logic [3:0] st;
    logic [5:0] stb;
  } cyc_t;

  ent_t tbl[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic add(input string nm, input logic [5:0] op, input logic [5:0] fn, input int k,
                     input logic [3:0] alu, input logic [1:0] srcb, input logic ext,
                     input logic [2:0] dm, input logic [1:0] a3, input logic aux);
    ent_t e;
    e.nm = nm; e.op = op; e.fn = fn; e.k = k; e.alu = alu; e.srcb = srcb;
    e.ext = ext; e.dm = dm; e.a3 = a3; e.aux = aux;
    tbl.push_back(e);
  endtask

  function automatic int find(input logic [31:0] w);
    for (int i = 0; i < tbl.size(); i++)
      if (tbl[i].op == w[31:26] && (w[31:26] != 6'd0 || tbl[i].fn == w[5:0])) return i;
    return -1;
  endfunction

  function automatic logic [5:0] strobes();
    return {pc_we, ir_we, dwe, gwe, md_start, illegal};
  endfunction

  // run one instruction starting in IF, checking every cycle against the expanded sequence
  task automatic run_instr(input logic [31:0] w);
    int    idx, k, n;
    string nm;
    ent_t  e;
    cyc_t  q[$];
    idx = find(w);
    k   = (idx < 0) ? K_ILL : tbl[idx].k;
    if (idx >= 0) e = tbl[idx];
    nm  = (idx < 0) ? "ill" : e.nm;
    q.push_back('{ST_IF, SB_IF});
    q.push_back('{ST_ID, (k == K_ILL) ? SB_ILL : SB_NONE});
    case (k)
      K_ALU: begin q.push_back('{ST_EX, SB_NONE}); q.push_back('{ST_WB, SB_GWE}); end
      K_LD: begin
        q.push_back('{ST_EX, SB_NONE}); q.push_back('{ST_MEM, SB_NONE}); q.push_back('{ST_WB, SB_GWE});
      end
      K_ST:  begin q.push_back('{ST_EX, SB_NONE}); q.push_back('{ST_MEM, SB_DWE}); end
      K_BR:  q.push_back('{ST_BR, SB_PC});
      K_J, K_JR: q.push_back('{ST_JMP, SB_PC});
      K_JAL: q.push_back('{ST_JMP, SB_PC | SB_GWE});
      K_MD: begin
        n = e.aux ? DIV_CYC : MULT_CYC;
        for (int j = 0; j < n; j++) q.push_back('{ST_MD, (j == 0) ? SB_MDS : SB_NONE});
      end
      K_MF:  q.push_back('{ST_WB, SB_GWE});
      default: ;
    endcase
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
        if (i == 1) instr = w;
        #1;
      end
      chk($sformatf("%s_c%0d_state", nm, i), 32'(state), 32'(q[i].st));
      chk($sformatf("%s_c%0d_strobes", nm, i), 32'(strobes()), 32'(q[i].stb));
      case (q[i].st)
        ST_IF: chk($sformatf("%s_if_npc", nm), 32'(npc_sel), 32'd0);
        ST_EX: begin
          chk($sformatf("%s_ex_alu", nm), 32'(alu_ctrl), 32'(e.alu));
          chk($sformatf("%s_ex_srcb", nm), 32'(srcb_sel), 32'(e.srcb));
          if (e.op != 6'd0) chk($sformatf("%s_ex_ext", nm), 32'(ext_op), 32'(e.ext));
        end
        ST_MEM: chk($sformatf("%s_mem_dm", nm), 32'(dm_sel), 32'(e.dm));
        ST_WB: begin
          chk($sformatf("%s_wb_gwd", nm), 32'(gwd_sel), (k == K_MF) ? 32'd3 : (k == K_LD) ? 32'd1 : 32'd0);
          chk($sformatf("%s_wb_a3", nm), 32'(a3_sel), 32'(e.a3));
          if (k == K_MF) chk($sformatf("%s_wb_hilo", nm), 32'(hilo_sel), 32'(e.aux));
        end
        ST_BR: begin
          chk($sformatf("%s_br_npc", nm), 32'(npc_sel), 32'd1);
          chk($sformatf("%s_br_alu", nm), 32'(alu_ctrl), 32'd6);
        end
        ST_JMP: begin
          chk($sformatf("%s_jmp_npc", nm), 32'(npc_sel), (k == K_JR) ? 32'd3 : 32'd2);
          if (k == K_JAL) begin
            chk("jal_a3", 32'(a3_sel), 32'd2);
            chk("jal_gwd", 32'(gwd_sel), 32'd2);
          end
        end
        ST_MD: chk($sformatf("%s_md_op", nm), 32'(md_op), 32'(e.aux));
        default: ;
      endcase
    end
    @(posedge clk); #2;
  endtask

  // start an instruction, assert reset after ncyc cycles and check the recovery
  task automatic abort_test(input string nm, input logic [31:0] w, input int ncyc, input logic [3:0] st_at);
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk); #1;
      if (i == 1) instr = w;
      #1;
    end
    chk({nm, "_pre_state"}, 32'(state), 32'(st_at));
    reset = 1'b1; #1;
    chk({nm, "_rst_strobes"}, 32'(strobes()), 32'(SB_NONE));
    @(posedge clk); #2;
    chk({nm, "_rst_state"}, 32'(state), 32'(ST_IF));
    chk({nm, "_rst_strobes2"}, 32'(strobes()), 32'(SB_NONE));
    reset = 1'b0; #1;
    chk({nm, "_release"}, 32'(strobes()), 32'(SB_IF));
  endtask

  initial begin
    logic [31:0] w;
    int          r;
    add("addu", 6'h00, 6'h21, K_ALU, 4'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0);
    add("subu", 6'h00, 6'h23, K_ALU, 4'd1, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0);
    add("sll",  6'h00, 6'h00, K_ALU, 4'd3, 2'd2, 1'b1, 3'd0, 2'd1, 1'b0);
    add("ori",  6'h0d, 6'h00, K_ALU, 4'd2, 2'd1, 1'b0, 3'd0, 2'd0, 1'b0);
    add("lui",  6'h0f, 6'h00, K_ALU, 4'd4, 2'd1, 1'b0, 3'd0, 2'd0, 1'b0);
    add("slti", 6'h0a, 6'h00, K_ALU, 4'd5, 2'd1, 1'b1, 3'd0, 2'd0, 1'b0);
    add("lw",   6'h23, 6'h00, K_LD,  4'd0, 2'd1, 1'b1, 3'd0, 2'd0, 1'b0);
    add("lh",   6'h21, 6'h00, K_LD,  4'd0, 2'd1, 1'b1, 3'd1, 2'd0, 1'b0);
    add("lhu",  6'h25, 6'h00, K_LD,  4'd0, 2'd1, 1'b1, 3'd2, 2'd0, 1'b0);
    add("lb",   6'h20, 6'h00, K_LD,  4'd0, 2'd1, 1'b1, 3'd3, 2'd0, 1'b0);
    add("lbu",  6'h24, 6'h00, K_LD,  4'd0, 2'd1, 1'b1, 3'd4, 2'd0, 1'b0);
    add("sw",   6'h2b, 6'h00, K_ST,  4'd0, 2'd1, 1'b1, 3'd0, 2'd0, 1'b0);
    add("sh",   6'h29, 6'h00, K_ST,  4'd0, 2'd1, 1'b1, 3'd1, 2'd0, 1'b0);
    add("sb",   6'h28, 6'h00, K_ST,  4'd0, 2'd1, 1'b1, 3'd3, 2'd0, 1'b0);
    add("beq",  6'h04, 6'h00, K_BR,  4'd6, 2'd0, 1'b1, 3'd0, 2'd0, 1'b0);
    add("bgtz", 6'h07, 6'h00, K_BR,  4'd6, 2'd0, 1'b1, 3'd0, 2'd0, 1'b0);
    add("j",    6'h02, 6'h00, K_J,   4'd0, 2'd0, 1'b1, 3'd0, 2'd0, 1'b0);
    add("jal",  6'h03, 6'h00, K_JAL, 4'd0, 2'd0, 1'b1, 3'd0, 2'd2, 1'b0);
    add("jr",   6'h00, 6'h08, K_JR,  4'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0);
    add("mult", 6'h00, 6'h18, K_MD,  4'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0);
    add("div",  6'h00, 6'h1a, K_MD,  4'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b1);
    add("mfhi", 6'h00, 6'h10, K_MF,  4'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0);
    add("mflo", 6'h00, 6'h12, K_MF,  4'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b1);

    reset = 1'b1;
    instr = 32'h0000_0000;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_state", 32'(state), 32'(ST_IF));
      chk("reset_strobes", 32'(strobes()), 32'(SB_NONE));
    end
    reset = 1'b0; #1;
    chk("first_if_strobes", 32'(strobes()), 32'(SB_IF));

    run_instr(32'h0022_1821);   // addu $3,$1,$2
    run_instr(32'h8C25_0004);   // lw   $5,4($1)
    run_instr(32'hAC25_0008);   // sw   $5,8($1)
    run_instr(32'h0C10_0004);   // jal  0x00400010
    run_instr(32'h0022_001A);   // div  $1,$2
    run_instr(32'h0000_2012);   // mflo $4
    run_instr(32'hFC00_0000);   // unrecognised opcode

    abort_test("rst_mem", 32'h8C25_0004, 3, ST_MEM);
    run_instr(32'h0022_0018);   // mult after reset
    abort_test("rst_md", 32'h0022_001A, 5, ST_MD);
    run_instr(32'h0022_001A);   // div runs its full length again

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 7);
      w = $urandom;
      if (r != 0) begin
        r = $urandom_range(0, tbl.size() - 1);
        w[31:26] = tbl[r].op;
        if (tbl[r].op == 6'd0) w[5:0] = tbl[r].fn;
      end
      run_instr(w);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
